ddr3_partial_wr_gate: RTL and testbench

Configurable write-burst gate between the DDR3 DFI sequencer write-data outputs and the DFI PHY. Per write burst, it applies a queued directive from a small configuration FIFO. The directive selects a beat window and a mode: pass, truncate, mask or invert. This is the parametrised successor of the fixed truncate-only wrapper. It adds selectable start offset, per-burst queued settings, seamless back-to-back burst handling and optional statistics.

---
 rtl/ddr3_partial_wr_gate_if.sv | 37 +++
 rtl/ddr3_partial_wr_gate.sv | 161 ++++++++++++++++
 tb/tb_ddr3_partial_wr_gate.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_partial_wr_gate_if.sv
// Bus bundle for ddr3_partial_wr_gate: directive queue push, sequencer write data, gated DFI
// write data and burst status. master = sequencer/config side, slave = the gate.
interface ddr3_partial_wr_gate_if #(
  parameter int unsigned DDR_DATA_W = 32,
  parameter int unsigned DDR_DQM_W  = 4,
  parameter int unsigned BEAT_W     = 4
);
  logic                  cfg_valid_i;
  logic                  cfg_ready_o;
  logic [1:0]            cfg_mode_i;
  logic [BEAT_W-1:0]     cfg_start_i;
  logic [BEAT_W-1:0]     cfg_len_i;
  logic [DDR_DATA_W-1:0] seq_wrdata_i;
  logic                  seq_wrdata_en_i;
  logic [DDR_DQM_W-1:0]  seq_wrdata_mask_i;
  logic [DDR_DATA_W-1:0] dfi_wrdata_o;
  logic                  dfi_wrdata_en_o;
  logic [DDR_DQM_W-1:0]  dfi_wrdata_mask_o;
  logic                  burst_done_o;
  logic                  no_cfg_o;
  logic [15:0]           stat_bursts_o;
  logic [15:0]           stat_cut_o;

  modport master (
    output cfg_valid_i, cfg_mode_i, cfg_start_i, cfg_len_i,
    output seq_wrdata_i, seq_wrdata_en_i, seq_wrdata_mask_i,
    input  cfg_ready_o, dfi_wrdata_o, dfi_wrdata_en_o, dfi_wrdata_mask_o,
    input  burst_done_o, no_cfg_o, stat_bursts_o, stat_cut_o
  );

  modport slave (
    input  cfg_valid_i, cfg_mode_i, cfg_start_i, cfg_len_i,
    input  seq_wrdata_i, seq_wrdata_en_i, seq_wrdata_mask_i,
    output cfg_ready_o, dfi_wrdata_o, dfi_wrdata_en_o, dfi_wrdata_mask_o,
    output burst_done_o, no_cfg_o, stat_bursts_o, stat_cut_o
  );
endinterface

// File: rtl/ddr3_partial_wr_gate.sv
// DFI write-burst gate: each burst pops a queued {mode,start,len} directive and gates beats
// outside the window. Define DDR_PARTIAL_STATS_EN to build the burst/cut statistics counters.
module ddr3_partial_wr_gate #(
  parameter int unsigned DDR_DATA_W  = 32,
  parameter int unsigned DDR_DQM_W   = 4,
  parameter int unsigned BURST_BEATS = 4,
  parameter int unsigned BEAT_W      = 4,
  parameter int unsigned CFG_DEPTH   = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  ddr3_partial_wr_gate_if.slave bus
);
  localparam int unsigned PtrW = (CFG_DEPTH > 1) ? $clog2(CFG_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(CFG_DEPTH + 1);
  localparam logic [BEAT_W-1:0] LastIdx = BEAT_W'(BURST_BEATS - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  typedef struct packed {
    logic [1:0]        mode;
    logic [BEAT_W-1:0] start;
    logic [BEAT_W-1:0] len;
  } cfg_t;

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;
  cfg_t              cfg_q, cfg_d;

  cfg_t              fifo_q [CFG_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              ready_q;

  logic [DDR_DATA_W-1:0] data_q, data_d;
  logic [DDR_DQM_W-1:0]  mask_q, mask_d;
  logic                  en_q, en_d;
  logic                  done_q, done_d;
  logic                  no_cfg_q, no_cfg_d;

  logic              beat, burst_start, push, pop, fifo_empty, in_win;
  logic [BEAT_W-1:0] cur_idx;
  cfg_t              cur_cfg;

  assign beat        = bus.seq_wrdata_en_i;
  assign burst_start = beat && ((state_q == StIdle) || (beat_idx_q == LastIdx));
  assign fifo_empty  = (count_q == '0);
  assign push        = bus.cfg_valid_i && ready_q;
  assign pop         = burst_start && !fifo_empty;

  // The directive popped on a burst-start beat already governs that beat.
  assign cur_cfg = burst_start ? (fifo_empty ? '0 : fifo_q[rd_ptr_q]) : cfg_q;
  assign cur_idx = burst_start ? '0 : beat_idx_q + BEAT_W'(1);
  assign in_win  = ({1'b0, cur_cfg.start} <= {1'b0, cur_idx}) &&
                   ({1'b0, cur_idx} < ({1'b0, cur_cfg.start} + {1'b0, cur_cfg.len}));

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    cfg_d      = cfg_q;
    unique case (state_q)
      StIdle:   if (beat) state_d = StActive;
      StActive: if (!beat) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (beat) beat_idx_d = cur_idx;
    if (burst_start) cfg_d = cur_cfg;
  end

  always_comb begin
    en_d     = beat;
    data_d   = bus.seq_wrdata_i;
    mask_d   = bus.seq_wrdata_mask_i;
    done_d   = beat && (cur_idx == LastIdx);
    no_cfg_d = burst_start && fifo_empty;
    if (beat && !in_win) begin
      case (cur_cfg.mode)
        2'd1:    en_d   = 1'b0;
        2'd2:    mask_d = '1;
        2'd3:    data_d = ~bus.seq_wrdata_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      beat_idx_q <= '0;
      cfg_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      data_q     <= '0;
      mask_q     <= '0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      no_cfg_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
      cfg_q      <= cfg_d;
      count_q    <= count_d;
      ready_q    <= (count_d < CntW'(CFG_DEPTH));
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      data_q     <= data_d;
      mask_q     <= mask_d;
      en_q       <= en_d;
      done_q     <= done_d;
      no_cfg_q   <= no_cfg_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= '{mode: bus.cfg_mode_i, start: bus.cfg_start_i,
                                    len: bus.cfg_len_i};
  end

  assign bus.cfg_ready_o       = ready_q;
  assign bus.dfi_wrdata_o      = data_q;
  assign bus.dfi_wrdata_en_o   = en_q;
  assign bus.dfi_wrdata_mask_o = mask_q;
  assign bus.burst_done_o      = done_q;
  assign bus.no_cfg_o          = no_cfg_q;

`ifdef DDR_PARTIAL_STATS_EN
  logic        cut;
  logic [15:0] stat_bursts_q, stat_cut_q;

  assign cut = beat && !in_win && (cur_cfg.mode != 2'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_bursts_q <= '0;
      stat_cut_q    <= '0;
    end else begin
      if (burst_start && (stat_bursts_q != 16'hFFFF)) stat_bursts_q <= stat_bursts_q + 16'd1;
      if (cut && (stat_cut_q != 16'hFFFF)) stat_cut_q <= stat_cut_q + 16'd1;
    end
  end

  assign bus.stat_bursts_o = stat_bursts_q;
  assign bus.stat_cut_o    = stat_cut_q;
`else
  assign bus.stat_bursts_o = '0;
  assign bus.stat_cut_o    = '0;
`endif

endmodule

// File: tb/tb_ddr3_partial_wr_gate.sv
// Directed self-checking bench for ddr3_partial_wr_gate (default parameters).
module tb_ddr3_partial_wr_gate;
  localparam int unsigned DataW = 32;
  localparam int unsigned DqmW  = 4;
  localparam int unsigned BeatW = 4;
  localparam int unsigned Depth = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_i = ~clk_i;

  ddr3_partial_wr_gate_if #(.DDR_DATA_W(DataW), .DDR_DQM_W(DqmW), .BEAT_W(BeatW)) bus ();

  ddr3_partial_wr_gate #(
    .DDR_DATA_W (DataW),
    .DDR_DQM_W  (DqmW),
    .BURST_BEATS(4),
    .BEAT_W     (BeatW),
    .CFG_DEPTH  (Depth)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [1:0] mode, input logic [3:0] start, input logic [3:0] len);
    bus.cfg_valid_i = 1'b1;
    bus.cfg_mode_i  = mode;
    bus.cfg_start_i = start;
    bus.cfg_len_i   = len;
    step();
    bus.cfg_valid_i = 1'b0;
  endtask

  // Drive one beat, then check the registered result one cycle later.
  task automatic beat_chk(input string tag, input logic [31:0] data, input logic [3:0] mask,
                          input logic exp_en, input logic [31:0] exp_data,
                          input logic [3:0] exp_mask, input logic exp_done,
                          input logic exp_nocfg);
    bus.seq_wrdata_en_i   = 1'b1;
    bus.seq_wrdata_i      = data;
    bus.seq_wrdata_mask_i = mask;
    step();
    check_eq({tag, ".en"}, 32'(bus.dfi_wrdata_en_o), 32'(exp_en));
    check_eq({tag, ".data"}, bus.dfi_wrdata_o, exp_data);
    check_eq({tag, ".mask"}, 32'(bus.dfi_wrdata_mask_o), 32'(exp_mask));
    check_eq({tag, ".done"}, 32'(bus.burst_done_o), 32'(exp_done));
    check_eq({tag, ".nocfg"}, 32'(bus.no_cfg_o), 32'(exp_nocfg));
  endtask

  task automatic idle_chk(input string tag);
    bus.seq_wrdata_en_i   = 1'b0;
    bus.seq_wrdata_i      = 32'h1234_5678;
    bus.seq_wrdata_mask_i = 4'h5;
    step();
    check_eq({tag, ".en"}, 32'(bus.dfi_wrdata_en_o), 32'd0);
    check_eq({tag, ".data"}, bus.dfi_wrdata_o, 32'h1234_5678);
    check_eq({tag, ".mask"}, 32'(bus.dfi_wrdata_mask_o), 32'h5);
    check_eq({tag, ".done"}, 32'(bus.burst_done_o), 32'd0);
  endtask

  initial begin
    logic [31:0] t1_data [4];
    logic        t1_en   [4];
    logic [3:0]  t2_mask [4];
    logic        t4_en   [8];
    t1_data = '{32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 32'hD3D3_D3D3};
    t1_en   = '{1'b1, 1'b1, 1'b0, 1'b0};
    t2_mask = '{4'hF, 4'h0, 4'h0, 4'hF};
    t4_en   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    bus.cfg_valid_i       = 1'b0;
    bus.cfg_mode_i        = '0;
    bus.cfg_start_i       = '0;
    bus.cfg_len_i         = '0;
    bus.seq_wrdata_i      = '0;
    bus.seq_wrdata_en_i   = 1'b0;
    bus.seq_wrdata_mask_i = '0;

    rst_i = 1'b1;
    step();
    step();
    check_eq("rst.ready", 32'(bus.cfg_ready_o), 32'd0);
    check_eq("rst.en", 32'(bus.dfi_wrdata_en_o), 32'd0);
    check_eq("rst.data", bus.dfi_wrdata_o, 32'd0);
    check_eq("rst.mask", 32'(bus.dfi_wrdata_mask_o), 32'd0);
    check_eq("rst.done", 32'(bus.burst_done_o), 32'd0);
    check_eq("rst.nocfg", 32'(bus.no_cfg_o), 32'd0);
    check_eq("rst.stat_bursts", 32'(bus.stat_bursts_o), 32'd0);
    check_eq("rst.stat_cut", 32'(bus.stat_cut_o), 32'd0);
    rst_i = 1'b0;
    step();
    check_eq("rel.ready", 32'(bus.cfg_ready_o), 32'd1);

    // Truncate outside beats 0..1.
    push(2'd1, 4'd0, 4'd2);
    for (int i = 0; i < 4; i++)
      beat_chk($sformatf("trunc%0d", i), t1_data[i], 4'h0, t1_en[i], t1_data[i], 4'h0,
               i == 3, 1'b0);
    idle_chk("trunc.idle");

    // Mask outside beats 1..2.
    push(2'd2, 4'd1, 4'd2);
    for (int i = 0; i < 4; i++)
      beat_chk($sformatf("mask%0d", i), 32'h5555_0000 + 32'(i), 4'h0, 1'b1,
               32'h5555_0000 + 32'(i), t2_mask[i], i == 3, 1'b0);
    idle_chk("mask.idle");

    // Invert with an empty window: every beat inverted.
    push(2'd3, 4'd3, 4'd0);
    for (int i = 0; i < 4; i++)
      beat_chk($sformatf("inv%0d", i), 32'h0, 4'h3, 1'b1, 32'hFFFF_FFFF, 4'h3, i == 3, 1'b0);
    idle_chk("inv.idle");
`ifdef DDR_PARTIAL_STATS_EN
    // Cumulative: 2 truncated + 2 masked + 4 inverted beats over 3 bursts.
    check_eq("inv.stat_cut", 32'(bus.stat_cut_o), 32'd8);
    check_eq("inv.stat_bursts", 32'(bus.stat_bursts_o), 32'd3);
`else
    check_eq("inv.stat_cut", 32'(bus.stat_cut_o), 32'd0);
    check_eq("inv.stat_bursts", 32'(bus.stat_bursts_o), 32'd0);
`endif

    // Seamless back-to-back bursts with two queued directives.
    push(2'd1, 4'd0, 4'd1);
    push(2'd0, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++)
      beat_chk($sformatf("b2b%0d", i), 32'h7000_0000 + 32'(i), 4'h0, t4_en[i],
               32'h7000_0000 + 32'(i), 4'h0, (i == 3) || (i == 7), 1'b0);
    idle_chk("b2b.idle");

    // Empty FIFO: pass-through with a single no_cfg pulse.
    for (int i = 0; i < 4; i++)
      beat_chk($sformatf("nocfg%0d", i), 32'h9000_0000 + 32'(i), 4'h2, 1'b1,
               32'h9000_0000 + 32'(i), 4'h2, i == 3, i == 0);
    idle_chk("nocfg.idle");
`ifdef DDR_PARTIAL_STATS_EN
    check_eq("nocfg.stat_cut", 32'(bus.stat_cut_o), 32'd11);
    check_eq("nocfg.stat_bursts", 32'(bus.stat_bursts_o), 32'd6);
`endif

    // Fill the FIFO with Depth+1 pushes; the last one must be dropped.
    bus.cfg_valid_i = 1'b1;
    bus.cfg_mode_i  = 2'd1;
    bus.cfg_start_i = 4'd0;
    bus.cfg_len_i   = 4'd0;
    for (int i = 1; i <= Depth + 1; i++) begin
      step();
      check_eq($sformatf("fill%0d.ready", i), 32'(bus.cfg_ready_o), 32'(i < Depth));
    end
    bus.cfg_valid_i = 1'b0;

    // Four seamless fully-truncated bursts drain the FIFO.
    for (int i = 0; i < 16; i++) begin
      beat_chk($sformatf("drain%0d", i), 32'(i), 4'h0, 1'b0, 32'(i), 4'h0, (i % 4) == 3,
               1'b0);
      if (i == 0) check_eq("drain.ready_after_pop", 32'(bus.cfg_ready_o), 32'd1);
    end
    // Fifth burst finds the FIFO empty: proves the extra push was dropped.
    beat_chk("extra0", 32'hE0, 4'h0, 1'b1, 32'hE0, 4'h0, 1'b0, 1'b1);

    // Reset in the middle of that burst.
    rst_i                 = 1'b1;
    bus.seq_wrdata_en_i   = 1'b1;
    bus.seq_wrdata_i      = 32'hE1;
    step();
    check_eq("midrst.en", 32'(bus.dfi_wrdata_en_o), 32'd0);
    check_eq("midrst.ready", 32'(bus.cfg_ready_o), 32'd0);
    check_eq("midrst.stat_bursts", 32'(bus.stat_bursts_o), 32'd0);
    check_eq("midrst.stat_cut", 32'(bus.stat_cut_o), 32'd0);
    rst_i               = 1'b0;
    bus.seq_wrdata_en_i = 1'b0;
    step();
    check_eq("postrst.ready", 32'(bus.cfg_ready_o), 32'd1);
    check_eq("postrst.en", 32'(bus.dfi_wrdata_en_o), 32'd0);

    // FIFO was emptied and state is idle: a new burst starts at beat 0 with no directive.
    for (int i = 0; i < 4; i++)
      beat_chk($sformatf("postrst%0d", i), 32'hC000_0000 + 32'(i), 4'h0, 1'b1,
               32'hC000_0000 + 32'(i), 4'h0, i == 3, i == 0);
    idle_chk("postrst.idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
